// File: rtl/shift_reg_sequencer_if.sv
// shift_reg_sequencer_if: command valid/ready handshake between a command source and the sequencer
interface shift_reg_sequencer_if #(parameter int CNT_W = 4);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_op;
   logic [CNT_W-1:0] cmd_cnt;
   logic [3:0]       cmd_data;
   modport master (output cmd_valid, cmd_op, cmd_cnt, cmd_data, input cmd_ready);
   modport slave  (input cmd_valid, cmd_op, cmd_cnt, cmd_data, output cmd_ready);
endinterface

// File: rtl/shift_reg_sequencer.sv
// shift_reg_sequencer: runs clear/load/shift/rotate commands on a 4-bit universal shift register
module shift_reg_sequencer #(parameter int CNT_W = 4) (
   input  logic                 clk_i,
   input  logic                 clear_i,
   shift_reg_sequencer_if.slave cmd,
   input  logic                 ser_in_i,
   input  logic [3:0]           sr_q_i,
   output logic                 sr_s1_o,
   output logic                 sr_s0_o,
   output logic                 sr_msb_in_o,
   output logic                 sr_lsb_in_o,
   output logic [3:0]           sr_i_par_o,
   output logic                 sr_clear_b_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 ser_out_o
);
   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
   localparam logic [2:0] OP_CLEAR = 3'd1, OP_LOAD = 3'd2, OP_SHR = 3'd3,
                          OP_SHL = 3'd4, OP_ROR = 3'd5, OP_ROL = 3'd6;
   state_t           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic [3:0]       data_q, data_d;
   logic             ser_out_q, ser_out_d;
   logic             exec, right, left, load, new_shift;
   always_ff @(posedge clk_i) begin
      if (clear_i) begin
         state_q   <= IDLE;
         op_q      <= '0;
         rem_q     <= '0;
         data_q    <= '0;
         ser_out_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         rem_q     <= rem_d;
         data_q    <= data_d;
         ser_out_q <= ser_out_d;
      end
   end
   assign exec      = state_q == EXEC;
   assign right     = op_q == OP_SHR || op_q == OP_ROR;
   assign left      = op_q == OP_SHL || op_q == OP_ROL;
   assign load      = op_q == OP_LOAD;
   assign new_shift = cmd.cmd_op >= OP_SHR && cmd.cmd_op <= OP_ROL;
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      rem_d     = rem_q;
      data_d    = data_q;
      ser_out_d = ser_out_q;
      case (state_q)
         IDLE: if (cmd.cmd_valid) begin
            op_d   = cmd.cmd_op;
            data_d = cmd.cmd_data;
            if (cmd.cmd_op == OP_CLEAR || cmd.cmd_op == OP_LOAD) begin
               state_d = EXEC;
               rem_d   = CNT_W'(1);
            end else if (new_shift && cmd.cmd_cnt != '0) begin
               state_d = EXEC;
               rem_d   = cmd.cmd_cnt;
            end else state_d = DONE;
         end
         EXEC: begin
            rem_d     = rem_q - CNT_W'(1);
            state_d   = rem_q == CNT_W'(1) ? DONE : EXEC;
            ser_out_d = right ? sr_q_i[0] : left ? sr_q_i[3] : ser_out_q;
         end
         default: state_d = IDLE;
      endcase
   end
   // Rotates feed the outgoing end back in; plain shifts take the live serial input
   assign sr_s0_o      = exec & (right | load);
   assign sr_s1_o      = exec & (left | load);
   assign sr_msb_in_o  = exec & (op_q == OP_SHR ? ser_in_i : op_q == OP_ROR ? sr_q_i[0] : 1'b0);
   assign sr_lsb_in_o  = exec & (op_q == OP_SHL ? ser_in_i : op_q == OP_ROL ? sr_q_i[3] : 1'b0);
   assign sr_i_par_o   = exec && load ? data_q : 4'd0;
   assign sr_clear_b_o = ~(clear_i | (exec & op_q == OP_CLEAR));
   assign cmd.cmd_ready = state_q == IDLE;
   assign busy_o       = state_q != IDLE;
   assign done_o       = state_q == DONE;
   assign ser_out_o    = ser_out_q;
endmodule

// File: tb/tb_shift_reg_sequencer.sv
// tb_shift_reg_sequencer: drives commands into the sequencer with a behavioural shift register attached
module tb_shift_reg_sequencer;
   localparam int CNT_W = 4;
   logic       clk = 1'b0, clear = 1'b1, ser_in = 1'b0;
   logic [3:0] sr_q = 4'hA;
   logic       s1, s0, msb_in, lsb_in, clear_b, busy, done, ser_out;
   logic [3:0] i_par;
   int         n_cmp = 0, n_bad = 0;
   logic [3:0] cur = 4'd0;
   logic       exp_ser = 1'b0;
   shift_reg_sequencer_if #(.CNT_W(CNT_W)) cmd_if ();
   shift_reg_sequencer #(.CNT_W(CNT_W)) dut (
      .clk_i(clk), .clear_i(clear), .cmd(cmd_if.slave), .ser_in_i(ser_in), .sr_q_i(sr_q),
      .sr_s1_o(s1), .sr_s0_o(s0), .sr_msb_in_o(msb_in), .sr_lsb_in_o(lsb_in),
      .sr_i_par_o(i_par), .sr_clear_b_o(clear_b), .busy_o(busy), .done_o(done), .ser_out_o(ser_out)
   );
   always #5 clk = ~clk;
   // the attached universal shift register: clear wins, then mode select
   always @(posedge clk) begin
      if (!clear_b) sr_q <= 4'd0;
      else case ({s1, s0})
         2'b01: sr_q <= {msb_in, sr_q[3:1]};
         2'b10: sr_q <= {sr_q[2:0], lsb_in};
         2'b11: sr_q <= i_par;
         default: sr_q <= sr_q;
      endcase
   end
   task automatic run_cmd(input logic [2:0] op, input int cnt, input logic [3:0] data,
                          input int ser_pat, input bit hold);
      int         n;
      logic [3:0] seq [0:16];
      logic       bits [0:15];
      logic [3:0] v;
      logic [1:0] mode;
      logic       e_msb, e_lsb;
      logic [11:0] obs, exp;
      n = (op == 3'd1 || op == 3'd2) ? 1 : (op >= 3'd3 && op <= 3'd6) ? cnt : 0;
      seq[0] = cur;
      for (int i = 0; i < n; i++) begin
         bits[i] = ser_pat == 2 ? 1'($urandom % 2) : 1'(ser_pat);
         v = seq[i];
         case (op)
            3'd1: seq[i+1] = 4'd0;
            3'd2: seq[i+1] = data;
            3'd3: begin seq[i+1] = 4'((v >> 1) + (bits[i] ? 8 : 0)); exp_ser = v[0]; end
            3'd4: begin seq[i+1] = 4'((v << 1) + (bits[i] ? 1 : 0)); exp_ser = v[3]; end
            3'd5: begin seq[i+1] = 4'((v >> 1) + (v[0] ? 8 : 0)); exp_ser = v[0]; end
            default: begin seq[i+1] = 4'((v << 1) + (v[3] ? 1 : 0)); exp_ser = v[3]; end
         endcase
      end
      n_cmp++;
      if (cmd_if.cmd_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL ready_before_cmd op=%0d: got %b want 1", op, cmd_if.cmd_ready);
      end
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_op    = op;
      cmd_if.cmd_cnt   = CNT_W'(cnt);
      cmd_if.cmd_data  = data;
      @(negedge clk);
      if (!hold) cmd_if.cmd_valid = 1'b0;
      for (int i = 1; i <= n + 1; i++) begin
         if (i <= n) ser_in = bits[i-1];
         #1;
         mode  = i > n ? 2'b00 : op == 3'd2 ? 2'b11 : (op == 3'd3 || op == 3'd5) ? 2'b01 :
                 (op == 3'd4 || op == 3'd6) ? 2'b10 : 2'b00;
         e_msb = i <= n && (op == 3'd3 ? bits[i-1] : op == 3'd5 ? seq[i-1][0] : 1'b0);
         e_lsb = i <= n && (op == 3'd4 ? bits[i-1] : op == 3'd6 ? seq[i-1][3] : 1'b0);
         exp   = {i == n + 1, 1'b1, 1'b0, mode, e_msb, e_lsb, !(i <= n && op == 3'd1),
                  (i <= n && op == 3'd2) ? data : 4'd0};
         obs   = {done, busy, cmd_if.cmd_ready, s1, s0, msb_in, lsb_in, clear_b, i_par};
         n_cmp++;
         if (obs !== exp) begin
            n_bad++;
            $display("FAIL ctrl op=%0d cnt=%0d cycle=%0d: got %b want %b (done,busy,ready,s1,s0,msb,lsb,clr_b,par)",
                     op, cnt, i, obs, exp);
         end
         n_cmp++;
         if (sr_q !== seq[i-1]) begin
            n_bad++;
            $display("FAIL sr_q op=%0d cnt=%0d cycle=%0d: got %b want %b", op, cnt, i, sr_q, seq[i-1]);
         end
         @(negedge clk);
      end
      cur = seq[n];
      #1;
      obs = {done, busy, cmd_if.cmd_ready, ser_out, 4'd0, sr_q};
      exp = {1'b0, 1'b0, 1'b1, exp_ser, 4'd0, cur};
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL end op=%0d cnt=%0d: got %b want %b (done,busy,ready,ser_out,0000,sr_q)", op, cnt, obs, exp);
      end
   endtask
   task automatic test_reset();
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_op    = 3'd2;
      cmd_if.cmd_cnt   = '0;
      cmd_if.cmd_data  = 4'hF;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         #1;
         n_cmp++;
         if ({clear_b, s1, s0, busy, done} !== 5'b00000) begin
            n_bad++;
            $display("FAIL reset_hold: got %b want 00000 (clr_b,s1,s0,busy,done)", {clear_b, s1, s0, busy, done});
         end
      end
      clear = 1'b0;
      cmd_if.cmd_valid = 1'b0;
      @(negedge clk);
      #1;
      n_cmp++;
      if ({cmd_if.cmd_ready, busy, ser_out, sr_q, i_par} !== {3'b100, 8'h00}) begin
         n_bad++;
         $display("FAIL reset_release: got %b want 10000000000 (ready,busy,ser_out,sr_q,par)",
                  {cmd_if.cmd_ready, busy, ser_out, sr_q, i_par});
      end
   endtask
   task automatic test_load_shift();
      run_cmd(3'd2, 0, 4'b1011, 0, 1'b0);
      run_cmd(3'd3, 3, 4'd0, 1, 1'b0);
   endtask
   task automatic test_rotate();
      run_cmd(3'd2, 0, 4'b1000, 0, 1'b0);
      run_cmd(3'd6, 1, 4'd0, 2, 1'b0);
      run_cmd(3'd2, 0, 4'b1011, 0, 1'b0);
      run_cmd(3'd5, 4, 4'd0, 2, 1'b0);
      run_cmd(3'd5, 0, 4'd0, 2, 1'b0);
      run_cmd(3'd6, 15, 4'd0, 2, 1'b0);
   endtask
   task automatic test_abort();
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_op    = 3'd4;
      cmd_if.cmd_cnt   = CNT_W'(8);
      @(negedge clk);
      cmd_if.cmd_valid = 1'b0;
      ser_in = 1'b1;
      @(negedge clk);
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         n_cmp++;
         if ({done, busy, cmd_if.cmd_ready, ser_out, sr_q} !== 8'b0010_0000) begin
            n_bad++;
            $display("FAIL abort cycle=%0d: got %b want 00100000 (done,busy,ready,ser_out,sr_q)",
                     i, {done, busy, cmd_if.cmd_ready, ser_out, sr_q});
         end
         @(negedge clk);
      end
      cur = 4'd0;
      exp_ser = 1'b0;
      run_cmd(3'd2, 0, 4'b0110, 0, 1'b0);
   endtask
   task automatic test_back_to_back();
      run_cmd(3'd6, 2, 4'd0, 2, 1'b1);
      run_cmd(3'd3, 3, 4'd0, 2, 1'b1);
      run_cmd(3'd0, 5, 4'd0, 2, 1'b1);
      run_cmd(3'd1, 0, 4'd0, 2, 1'b0);
   endtask
   task automatic test_random();
      for (int t = 0; t < 60; t++)
         run_cmd(3'($urandom_range(0, 7)), int'($urandom_range(0, 15)), 4'($urandom),
                 2, t != 59 && ($urandom % 2) == 1);
   endtask
   initial begin
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_op    = '0;
      cmd_if.cmd_cnt   = '0;
      cmd_if.cmd_data  = '0;
      test_reset();
      test_load_shift();
      test_rotate();
      test_abort();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/shift_reg_sequencer.md
# shift_reg_sequencer

Command-driven controller for the 4-bit universal shift register, which is a hold/shift-right/shift-left/parallel-load datapath. It accepts one command at a time over a valid/ready handshake and then drives the register's mode select, serial inputs, parallel input and clear for the exact number of cycles the command needs. It handles clear, load, serial shift and rotate. It reports completion with a one-cycle `done` pulse and returns the serial bit shifted out.

## Interface
- `CNT_W`, 4: width of shift/rotate count; max count 2^CNT_W-1.
- `CLK`  in  1  system clock, rising edge.
- `Clear`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  sequencer can accept; high only in IDLE.
- `cmd_op`  in  3  opcode: 000 NOP, 001 CLEAR, 010 LOAD, 011 SHR, 100 SHL, 101 ROR, 110 ROL, 111 reserved (acts as NOP).
- `cmd_cnt`  in  CNT_W  number of shift/rotate steps; ignored for other ops.
- `cmd_data`  in  4  parallel value for LOAD.
- `ser_in`  in  1  serial data entering during SHR/SHL, sampled live each shift cycle.
- `sr_q`  in  4  register parallel output (A_par) fed back.
- `sr_s1`, `sr_s0`  out  1 each  register mode: 00 hold, 01 shift right (MSB_in→bit3, bit0 leaves), 10 shift left (LSB_in→bit0, bit3 leaves), 11 parallel load.
- `sr_msb_in`, `sr_lsb_in`  out  1 each  register serial inputs.
- `sr_i_par`  out  4  register parallel input.
- `sr_clear_b`  out  1  register active-low clear.
- `busy`  out  1  command in progress (EXEC or DONE).
- `done`  out  1  one-cycle completion pulse.
- `ser_out`  out  1  last bit shifted/rotated out.

## Operation
- States: IDLE, EXEC, DONE.
- IDLE: `cmd_ready`=1 and select 00. A handshake (`cmd_valid`&`cmd_ready` at an edge) latches op, cnt and data.
  - CLEAR and LOAD go to EXEC with remaining=1.
  - Shift and rotate go to EXEC with remaining=cnt, or straight to DONE if cnt=0.
  - NOP and reserved go straight to DONE.
- EXEC: drive the mode for the op every cycle; decrement remaining at each edge; go to DONE at the edge where remaining=1.
  - CLEAR: select 00, `sr_clear_b`=0.
  - LOAD: select 11, `sr_i_par`=latched data.
  - SHR: select 01, `sr_msb_in`=`ser_in`.
  - SHL: select 10, `sr_lsb_in`=`ser_in`.
  - ROR: select 01, `sr_msb_in`=`sr_q[0]`.
  - ROL: select 10, `sr_lsb_in`=`sr_q[3]`.
- `sr_msb_in`, `sr_lsb_in` and `sr_clear_b` are combinational from state, `ser_in`, `sr_q` and `Clear`. Select and `sr_i_par` are decoded from registered state/op.
  - `sr_i_par`=0 outside LOAD.
  - Unused serial inputs are 0.
- `ser_out`: at each SHR/ROR edge it captures `sr_q[0]`; at each SHL/ROL edge it captures `sr_q[3]`. It holds otherwise.
- DONE: select 00, `done`=1 for exactly one cycle, then IDLE.
- `cmd_valid` while not in IDLE is ignored. No queueing: the offered command must be held until accepted.
- `sr_clear_b` = ~(`Clear` | (EXEC & op==CLEAR)).

## Timing
- Reset (`Clear` high at an edge): state IDLE, `cmd_ready`=1, `busy`=0, `done`=0, `ser_out`=0, select 00, `sr_i_par`=0. `sr_clear_b`=0 while `Clear` is high.
- Reset mid-command aborts the command: no `done` pulse, register cleared, IDLE after the edge.
- Accept at edge k. The register updates at edges k+1 … k+n, with n=cnt for shift/rotate and n=1 for CLEAR/LOAD.
- `done` is high in the cycle after edge k+n, i.e. in cycle k+n+1 (edge k+n+1 closes it). For n=0, `done` is high in cycle k+1.
- `cmd_ready` reasserts the cycle after `done`. Command period is n+2 cycles (2 for zero-length commands).
- Rotate by 4 restores the original value. Count wraps only via `CNT_W`; `cmd_cnt`=2^CNT_W-1 is legal.

## Test plan
- Reset: hold `Clear` 2 cycles with `cmd_valid`=1 → `sr_clear_b`=0, select 00, `busy`=0, no accept; after release `cmd_ready`=1 and `sr_q`=0000.
- LOAD 1011 accepted at edge k → select 11 in cycle k+1; `sr_q`=1011 after edge k+1; `done` high only in cycle k+2.
- After LOAD 1011, SHR cnt=3 with `ser_in`=1 → `sr_q` goes 1101, 1110, 1111; `ser_out` 1,1,0; `done` in cycle k+4.
- ROL cnt=1 on 1000 → 0001. ROR cnt=4 on 1011 → 1011. ROR cnt=0 → `sr_q` unchanged, `done` in cycle k+1.
- SHL cnt=8: assert `Clear` in the 3rd EXEC cycle → no `done`, `sr_q`=0000, IDLE; a new LOAD 0110 then completes normally.
- Two commands back-to-back with `cmd_valid` held: the second is accepted only at the edge after the first command's `done` cycle; `cmd_ready` is low throughout EXEC and DONE.
